// File: rtl/flash_spi_reader.sv
// Single-bit SPI flash READ (0x03) engine driving the flash pads; returns 32-bit words, first byte in [7:0].
// Latency accept->rd_data_valid is 2 + 128*CLK_DIV cycles (2 + 64*CLK_DIV on a FLASH_SPI_CONT_READ_EN sequential hit).
// Backpressure: rd_ready only in IDLE (and HOLD with FLASH_SPI_CONT_READ_EN); requester holds rd_valid until taken.
module flash_spi_reader #(
    parameter int CLK_DIV  = 2,
    parameter int CSB_HIGH = 4
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        rd_valid,
    output logic        rd_ready,
    input  logic [23:0] rd_addr,
    output logic        rd_data_valid,
    output logic [31:0] rd_data,
    output logic        busy,
    output logic        flash_csb_core,
    output logic        flash_clk_core,
    output logic        flash_csb_oeb_core,
    output logic        flash_clk_oeb_core,
    output logic        flash_io0_oeb_core,
    output logic        flash_io1_oeb_core,
    output logic        flash_io0_ieb_core,
    output logic        flash_io1_ieb_core,
    output logic        flash_io0_do_core,
    output logic        flash_io1_do_core,
    input  logic        flash_io1_di_core
);
    localparam int GW = (CSB_HIGH > 1) ? $clog2(CSB_HIGH) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(CSB_HIGH - 1);
    localparam logic [GW-1:0] GAP_ONE  = GW'(1);
    localparam logic [3:0]    DIV_LAST = 4'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_GAP,
        S_IDLE,
        S_SHIFT_OUT,
        S_SHIFT_IN,
`ifdef FLASH_SPI_CONT_READ_EN
        S_HOLD,
`endif
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [GW-1:0]  gap_cnt_q, gap_cnt_d;
    logic [3:0]     div_cnt_q, div_cnt_d;
    logic [4:0]     bit_cnt_q, bit_cnt_d;
    logic           sck_q, sck_d;
    logic           csb_q, csb_d;
    logic           io0_q, io0_d;
    logic           busy_q, busy_d;
    logic           rd_data_valid_q, rd_data_valid_d;
    logic [31:0]    rd_data_q, rd_data_d;
    logic [30:0]    sr_q, sr_d;
    logic [31:0]    rx_q, rx_d;
    logic           start;
    logic [23:0]    start_addr;
    logic           half_end;
`ifdef FLASH_SPI_CONT_READ_EN
    logic [23:0]    last_addr_q, last_addr_d;
    logic [23:0]    pend_addr_q, pend_addr_d;
    logic           pend_q, pend_d;
`endif

    always_comb begin
        state_d         = state_q;
        gap_cnt_d       = gap_cnt_q;
        div_cnt_d       = div_cnt_q;
        bit_cnt_d       = bit_cnt_q;
        sck_d           = sck_q;
        csb_d           = csb_q;
        io0_d           = io0_q;
        busy_d          = busy_q;
        rd_data_valid_d = 1'b0;
        rd_data_d       = rd_data_q;
        sr_d            = sr_q;
        rx_d            = rx_q;
        start           = 1'b0;
        start_addr      = rd_addr;
        half_end        = (div_cnt_q == DIV_LAST);
`ifdef FLASH_SPI_CONT_READ_EN
        last_addr_d     = last_addr_q;
        pend_addr_d     = pend_addr_q;
        pend_d          = pend_q;
`endif
        case (state_q)
            S_GAP: begin
                csb_d = 1'b1;
                sck_d = 1'b0;
                io0_d = 1'b0;
                if (gap_cnt_q == GAP_LAST) begin
                    gap_cnt_d = '0;
                    state_d   = S_IDLE;
`ifdef FLASH_SPI_CONT_READ_EN
                    if (pend_q) begin
                        start      = 1'b1;
                        start_addr = pend_addr_q;
                        pend_d     = 1'b0;
                    end
`endif
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_ONE;
                end
            end
            S_IDLE: begin
                if (rd_valid) start = 1'b1;
            end
            S_SHIFT_OUT, S_SHIFT_IN: begin
                if (half_end) begin
                    div_cnt_d = 4'd0;
                    sck_d     = ~sck_q;
                    if (!sck_q) begin
                        if (state_q == S_SHIFT_IN) rx_d = {rx_q[30:0], flash_io1_di_core};
                    end else begin
                        // Falling SCK closes a bit: advance MOSI, or finish the phase.
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (state_q == S_SHIFT_OUT) begin
                            io0_d = sr_q[30];
                            sr_d  = {sr_q[29:0], 1'b0};
                            if (bit_cnt_q == 5'd31) begin
                                state_d = S_SHIFT_IN;
                                io0_d   = 1'b0;
                            end
                        end else if (bit_cnt_q == 5'd31) begin
                            state_d = S_DONE;
                        end
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 4'd1;
                end
            end
            S_DONE: begin
                sck_d           = 1'b0;
                busy_d          = 1'b0;
                rd_data_valid_d = 1'b1;
                rd_data_d       = {rx_q[7:0], rx_q[15:8], rx_q[23:16], rx_q[31:24]};
`ifdef FLASH_SPI_CONT_READ_EN
                state_d         = S_HOLD;
`else
                csb_d           = 1'b1;
                state_d         = S_GAP;
`endif
            end
`ifdef FLASH_SPI_CONT_READ_EN
            S_HOLD: begin
                if (rd_valid) begin
                    busy_d = 1'b1;
                    if (rd_addr == last_addr_q + 24'd4) begin
                        state_d     = S_SHIFT_IN;
                        div_cnt_d   = 4'd0;
                        sck_d       = 1'b0;
                        bit_cnt_d   = 5'd0;
                        last_addr_d = rd_addr;
                    end else begin
                        state_d     = S_GAP;
                        gap_cnt_d   = '0;
                        csb_d       = 1'b1;
                        pend_d      = 1'b1;
                        pend_addr_d = rd_addr;
                    end
                end
            end
`endif
            default: state_d = S_GAP;
        endcase

        if (start) begin
            state_d   = S_SHIFT_OUT;
            csb_d     = 1'b0;
            busy_d    = 1'b1;
            div_cnt_d = 4'd0;
            bit_cnt_d = 5'd0;
            sck_d     = 1'b0;
            // Command MSB (bit 7 of 0x03) is 0 and goes out first; the rest waits in sr.
            io0_d     = 1'b0;
            sr_d      = {7'h03, start_addr};
`ifdef FLASH_SPI_CONT_READ_EN
            last_addr_d = start_addr;
`endif
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q         <= S_GAP;
            gap_cnt_q       <= '0;
            div_cnt_q       <= 4'd0;
            bit_cnt_q       <= 5'd0;
            sck_q           <= 1'b0;
            csb_q           <= 1'b1;
            io0_q           <= 1'b0;
            busy_q          <= 1'b0;
            rd_data_valid_q <= 1'b0;
            rd_data_q       <= 32'd0;
            sr_q            <= 31'd0;
            rx_q            <= 32'd0;
`ifdef FLASH_SPI_CONT_READ_EN
            last_addr_q     <= 24'd0;
            pend_addr_q     <= 24'd0;
            pend_q          <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            gap_cnt_q       <= gap_cnt_d;
            div_cnt_q       <= div_cnt_d;
            bit_cnt_q       <= bit_cnt_d;
            sck_q           <= sck_d;
            csb_q           <= csb_d;
            io0_q           <= io0_d;
            busy_q          <= busy_d;
            rd_data_valid_q <= rd_data_valid_d;
            rd_data_q       <= rd_data_d;
            sr_q            <= sr_d;
            rx_q            <= rx_d;
`ifdef FLASH_SPI_CONT_READ_EN
            last_addr_q     <= last_addr_d;
            pend_addr_q     <= pend_addr_d;
            pend_q          <= pend_d;
`endif
        end
    end

`ifdef FLASH_SPI_CONT_READ_EN
    assign rd_ready = (state_q == S_IDLE) || (state_q == S_HOLD);
`else
    assign rd_ready = (state_q == S_IDLE);
`endif
    assign rd_data_valid      = rd_data_valid_q;
    assign rd_data            = rd_data_q;
    assign busy               = busy_q;
    assign flash_csb_core     = csb_q;
    assign flash_clk_core     = sck_q;
    assign flash_io0_do_core  = io0_q;
    assign flash_csb_oeb_core = 1'b0;
    assign flash_clk_oeb_core = 1'b0;
    assign flash_io0_oeb_core = 1'b0;
    assign flash_io1_oeb_core = 1'b1;
    assign flash_io0_ieb_core = 1'b1;
    assign flash_io1_ieb_core = 1'b0;
    assign flash_io1_do_core  = 1'b0;
endmodule

// File: tb/tb_flash_spi_reader.sv
// Directed bench for flash_spi_reader: instance 0 at CLK_DIV=2, instance 1 at CLK_DIV=1,
// each attached to a mode-0 SPI flash model backed by a fixed byte map.
`timescale 1ns/1ps
module tb_flash_spi_reader;
    localparam int CSB_HIGH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  rst, rd_valid, rd_ready, rd_data_valid, busy, csb, sck;
    logic [1:0]  csb_oeb, clk_oeb, io0_oeb, io1_oeb, io0_ieb, io1_ieb, io0_do, io1_do, miso;
    logic [23:0] rd_addr [2];
    logic [31:0] rd_data [2];
    logic [31:0] m_cmd [2];
    int          m_bits [2];
    int          m_csb_rises [2];
    int          m_high_len [2];
    int          m_period [2];
    int          m_viol [2];
    int          n_tests = 0;
    int          n_fail  = 0;

    function automatic logic [7:0] mem_byte(input logic [23:0] a);
        case (a)
            24'h000104: mem_byte = 8'hEF;
            24'h000105: mem_byte = 8'hBE;
            24'h000106: mem_byte = 8'hAD;
            24'h000107: mem_byte = 8'hDE;
            default:    mem_byte = a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'hA5;
        endcase
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_inst
        flash_spi_reader #(.CLK_DIV((g == 0) ? 2 : 1), .CSB_HIGH(CSB_HIGH)) u_dut (
            .wb_clk_i          (clk),
            .wb_rst_i          (rst[g]),
            .rd_valid          (rd_valid[g]),
            .rd_ready          (rd_ready[g]),
            .rd_addr           (rd_addr[g]),
            .rd_data_valid     (rd_data_valid[g]),
            .rd_data           (rd_data[g]),
            .busy              (busy[g]),
            .flash_csb_core    (csb[g]),
            .flash_clk_core    (sck[g]),
            .flash_csb_oeb_core(csb_oeb[g]),
            .flash_clk_oeb_core(clk_oeb[g]),
            .flash_io0_oeb_core(io0_oeb[g]),
            .flash_io1_oeb_core(io1_oeb[g]),
            .flash_io0_ieb_core(io0_ieb[g]),
            .flash_io1_ieb_core(io1_ieb[g]),
            .flash_io0_do_core (io0_do[g]),
            .flash_io1_do_core (io1_do[g]),
            .flash_io1_di_core (miso[g])
        );

        logic [31:0] cmd = '0;
        logic [31:0] data_p = '0;
        logic [7:0]  bv;
        logic        sck_p = 1'b0, csb_p = 1'b1, miso_r = 1'b0;
        int          bits = 0, rises = 0, high_run = 0, high_len = 0;
        int          tick = 0, last_rise = 0, period = 0, viol = 0, r;

        // Flash side: shift in MOSI on SCK rise, present MISO after SCK fall.
        always begin
            @(posedge clk);
            #1;
            tick++;
            if (rd_data[g] !== data_p && !rd_data_valid[g] && !rst[g]) viol++;
            data_p = rd_data[g];
            if (csb[g]) begin
                if (!csb_p) rises++;
                high_run++;
            end else begin
                if (csb_p) begin
                    high_len = high_run;
                    high_run = 0;
                    bits     = 0;
                    cmd      = '0;
                end
                if (sck[g] && !sck_p) begin
                    if (bits < 32) cmd = {cmd[30:0], io0_do[g]};
                    bits++;
                    period    = tick - last_rise;
                    last_rise = tick;
                end else if (!sck[g] && sck_p && bits >= 32) begin
                    r      = bits - 32;
                    bv     = mem_byte(cmd[23:0] + 24'(r / 8));
                    miso_r = bv[7 - (r % 8)];
                end
            end
            csb_p = csb[g];
            sck_p = sck[g];
        end

        assign miso[g]        = miso_r;
        assign m_cmd[g]       = cmd;
        assign m_bits[g]      = bits;
        assign m_csb_rises[g] = rises;
        assign m_high_len[g]  = high_len;
        assign m_period[g]    = period;
        assign m_viol[g]      = viol;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_read(input int idx, input logic [23:0] addr, output int lat,
                           output logic [31:0] data, output logic busy_first,
                           output logic csb_at_valid);
        int w;
        w = 0;
        @(negedge clk);
        while (!rd_ready[idx] && w < 3000) begin
            @(negedge clk);
            w++;
        end
        rd_valid[idx] = 1'b1;
        rd_addr[idx]  = addr;
        lat           = 0;
        busy_first    = 1'b0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                rd_valid[idx] = 1'b0;
                busy_first    = busy[idx];
            end
        end while (!rd_data_valid[idx] && lat < 3000);
        data         = rd_data[idx];
        csb_at_valid = csb[idx];
        chk("read_done", 32'(rd_data_valid[idx]), 32'd1);
    endtask

    initial begin
        int          lat, w, acc, b0, r0, pulses;
        logic [31:0] d;
        logic        bf, cv;

        rst        = 2'b11;
        rd_valid   = 2'b00;
        rd_addr[0] = 24'd0;
        rd_addr[1] = 24'd0;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 2; i++) begin
            chk("rst_csb",   32'(csb[i]), 32'd1);
            chk("rst_sck",   32'(sck[i]), 32'd0);
            chk("rst_ready", 32'(rd_ready[i]), 32'd0);
            chk("rst_busy",  32'(busy[i]), 32'd0);
            chk("rst_dvld",  32'(rd_data_valid[i]), 32'd0);
            chk("rst_mosi",  32'(io0_do[i]), 32'd0);
            chk("rst_data",  rd_data[i], 32'd0);
            chk("tie_pads",  32'({csb_oeb[i], clk_oeb[i], io0_oeb[i], io1_oeb[i],
                                  io0_ieb[i], io1_ieb[i], io1_do[i]}), 32'b0001100);
        end
        rst = 2'b00;
        for (int k = 1; k <= CSB_HIGH; k++) begin
            @(negedge clk);
            chk("gap_ready", 32'(rd_ready[0]), (k == CSB_HIGH) ? 32'd1 : 32'd0);
            chk("gap_csb",   32'(csb[0]), 32'd1);
        end

        // Basic read at CLK_DIV=2
        do_read(0, 24'h000104, lat, d, bf, cv);
        chk("t2_latency", 32'(lat), 32'd258);
        chk("t2_data",    d, 32'hDEADBEEF);
        chk("t2_mosi",    m_cmd[0], 32'h03000104);
        chk("t2_busy_on", 32'(bf), 32'd1);
        chk("t2_busy_off", 32'(busy[0]), 32'd0);
`ifdef FLASH_SPI_CONT_READ_EN
        chk("t2_csb_hold", 32'(cv), 32'd0);
`else
        chk("t2_csb_up",  32'(cv), 32'd1);
`endif
        chk("t2_sck_period", 32'(m_period[0]), 32'd4);
        @(negedge clk);
        chk("t2_pulse_1cyc", 32'(rd_data_valid[0]), 32'd0);

        // Top-of-memory read at CLK_DIV=1
        do_read(1, 24'hFFFFFC, lat, d, bf, cv);
        chk("t3_latency", 32'(lat), 32'd130);
        chk("t3_data",    d, 32'h5A5B5859);
        chk("t3_mosi",    m_cmd[1], 32'h03FFFFFC);
        chk("t3_sck_period", 32'(m_period[1]), 32'd2);
`ifdef FLASH_SPI_CONT_READ_EN
        chk("t3_hold_ready", 32'(rd_ready[1]), 32'd1);
`else
        w = 0;
        while (!rd_ready[1] && csb[1] && w < 100) begin
            w++;
            @(negedge clk);
        end
        chk("t3_csb_gap", 32'(w), 32'(CSB_HIGH));
        chk("t3_ready_after_gap", 32'(rd_ready[1]), 32'd1);
`endif

        // Reset abort during the data phase
        w = 0;
        @(negedge clk);
        while (!rd_ready[0] && w < 3000) begin
            @(negedge clk);
            w++;
        end
        rd_valid[0] = 1'b1;
        rd_addr[0]  = 24'h000300;
        @(negedge clk);
        rd_valid[0] = 1'b0;
        w = 0;
        while (!(csb[0] == 1'b0 && m_bits[0] == 52) && w < 3000) begin
            @(negedge clk);
            w++;
        end
        chk("t4_reach_bit20", 32'(m_bits[0]), 32'd52);
        rst[0] = 1'b1;
        @(negedge clk);
        chk("t4_abort_csb",  32'(csb[0]), 32'd1);
        chk("t4_abort_sck",  32'(sck[0]), 32'd0);
        chk("t4_abort_busy", 32'(busy[0]), 32'd0);
        rst[0] = 1'b0;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (rd_data_valid[0]) pulses++;
            @(negedge clk);
        end
        chk("t4_no_valid", 32'(pulses), 32'd0);
        do_read(0, 24'h000200, lat, d, bf, cv);
        chk("t4_latency", 32'(lat), 32'd258);
        chk("t4_data",    d, 32'hA4A5A6A7);
        chk("t4_mosi",    m_cmd[0], 32'h03000200);

        // rd_valid held with a changing address; only the accepted one is sent
        w = 0;
        @(negedge clk);
        while (!rd_ready[0] && w < 3000) begin
            @(negedge clk);
            w++;
        end
        rd_valid[0] = 1'b1;
        rd_addr[0]  = 24'h00ABCD;
        lat = 0;
        acc = 0;
        do begin
            @(negedge clk);
            lat++;
            if (rd_ready[0] && !rd_data_valid[0]) acc++;
            rd_addr[0] = 24'($urandom);
        end while (!rd_data_valid[0] && lat < 3000);
        rd_valid[0] = 1'b0;
        chk("t6_done",   32'(rd_data_valid[0]), 32'd1);
        chk("t6_mosi",   m_cmd[0], 32'h0300ABCD);
        chk("t6_data",   rd_data[0], 32'hDEC1C0C3);
        chk("t6_no_reaccept", 32'(acc), 32'd0);

`ifdef FLASH_SPI_CONT_READ_EN
        // Continuous read: sequential hit skips command, jump reopens CSB
        do_read(0, 24'h000100, lat, d, bf, cv);
        chk("t5_first_data", d, 32'hA7A6A5A4);
        b0 = m_bits[0];
        r0 = m_csb_rises[0];
        do_read(0, 24'h000104, lat, d, bf, cv);
        chk("t5_seq_latency", 32'(lat), 32'd130);
        chk("t5_seq_data",    d, 32'hDEADBEEF);
        chk("t5_seq_bits",    32'(m_bits[0] - b0), 32'd32);
        chk("t5_seq_csb_low", 32'(m_csb_rises[0] - r0), 32'd0);
        chk("t5_seq_csb_at_valid", 32'(cv), 32'd0);
        do_read(0, 24'h000200, lat, d, bf, cv);
        chk("t5_jump_data", d, 32'hA4A5A6A7);
        chk("t5_jump_mosi", m_cmd[0], 32'h03000200);
        chk("t5_jump_gap",  32'(m_high_len[0]), 32'(CSB_HIGH));
`endif

        repeat (2) @(negedge clk);
        chk("data_stable0", 32'(m_viol[0]), 32'd0);
        chk("data_stable1", 32'(m_viol[1]), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
